cmp_debounce: RTL and testbench
===============================

// Module: cmp_debounce
// PURPOSE
//  Downstream stage of the 4-bit magnitude comparator: consumes its eq/lt/gt flags per sample.
//  Reports a debounced relation (EQ/LT/GT) that changes only after STABLE_CNT consecutive agreeing samples.
//  Flags illegal flag combinations. Feeds control logic that must not react to single-sample glitches.
// PARAMETERS
//  STABLE_CNT  4  consecutive valid samples required to change rel_o; legal range 1..255
//  CNT_W       8  width of the change counter (CMP_DEB_CNT_EN only)
// PORTS
//  clk        in   1      clock; all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      eq/lt/gt hold a new sample this cycle
//  eq         in   1      comparator a==b
//  lt         in   1      comparator a<b
//  gt         in   1      comparator a>b
//  rel_o      out  2      debounced relation: 0=EQ 1=LT 2=GT 3=UNK
//  changed_o  out  1      1-cycle pulse on the cycle rel_o takes a new value
//  err_o      out  1      1-cycle pulse, illegal sample captured
//  clr_cnt    in   1      clear change counter
//  chg_cnt_o  out  CNT_W  saturating count of changed_o pulses
// BEHAVIOUR
//  Reset: rel_o=UNK, changed_o=0, err_o=0, chg_cnt_o=0, cand=UNK, run=0, state=S_UNK.
//  All outputs are registered. rst wins over every other input in the same cycle, including mid-run.
//  Sample decode, legal only when exactly one flag is set:
//   (1,0,0)=EQ, (0,1,0)=LT, (0,0,1)=GT.
//   Any other combination is illegal: err_o=1 next cycle, run=0, cand=UNK, rel_o held.
//  in_valid=0: no state change. Gaps do not break a run.
//  FSM states: S_UNK (no relation reported), S_LOCK (rel_o stable, run=0), S_PEND (run>0 toward cand).
//  Valid legal sample s:
//   s==rel_o: run=0, cand=UNK, go to S_LOCK.
//   s!=rel_o and s==cand: run=run+1.
//   s!=rel_o and s!=cand: cand=s, run=1, go to S_PEND.
//  When run would reach STABLE_CNT, the following happens on that same edge instead of storing run:
//   rel_o=s, changed_o=1, run=0, cand=UNK, go to S_LOCK.
//  Latency: rel_o updates on the edge that captures the STABLE_CNT-th agreeing sample.
//  STABLE_CNT=1: every differing legal sample updates rel_o on its capture edge.
//  run width is 8 bits. run never exceeds STABLE_CNT-1.
//  changed_o and err_o are low in every cycle not described above.
// CONFIGURATION
//  CMP_DEB_CNT_EN defined:
//   chg_cnt_o increments by 1 on each changed_o pulse.
//   Saturates at 2**CNT_W-1. Does not wrap.
//   clr_cnt=1 forces 0, taking priority over an increment in the same cycle.
//  CMP_DEB_CNT_EN undefined:
//   chg_cnt_o is tied to 0 and clr_cnt is ignored. Port list is unchanged.
// STRUCTURE
//  Package cmp_pkg:
//   rel_t encoding: REL_EQ=2'd0, REL_LT=2'd1, REL_GT=2'd2, REL_UNK=2'd3.
//   FSM state enum.
//  Sub-module cmp_rel_encode: combinational eq/lt/gt -> {rel_t, illegal}. Reusable by other stages.
//  Top level contains the FSM, the run/cand registers and the optional counter.
// TESTING
//  STABLE_CNT=4, reset, then 4 valid EQ samples -> rel_o=EQ after 4th edge, changed_o=1 for exactly 1 cycle.
//  From EQ: LT,LT,GT,LT,LT,LT,LT -> rel_o=LT only after last LT. No change or pulse earlier.
//  From LT: GT,GT, in_valid=0 for 5 cycles, GT,GT -> rel_o=GT on 4th GT (gaps ignored).
//  Samples (1,1,0) and (0,0,0) -> err_o pulses on each. rel_o held. Pending run restarts at 1 on next legal sample.
//  rst asserted with run=3 pending GT -> rel_o=UNK next cycle. 3 further GT samples do not change rel_o.
//  CMP_DEB_CNT_EN, CNT_W=2: 5 changes -> chg_cnt_o=3 (saturated). clr_cnt together with a change -> 0.

Source files
------------

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared relation encoding and debounce FSM states for the
//               comparator debounce stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    typedef enum logic [1:0] {
        REL_EQ  = 2'd0,
        REL_LT  = 2'd1,
        REL_GT  = 2'd2,
        REL_UNK = 2'd3
    } rel_t;

    typedef enum logic [1:0] {
        S_UNK  = 2'd0,
        S_LOCK = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam int c_RUN_W = 8;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/cmp_rel_encode.sv
`default_nettype none
// ============================================================================
// Module      : cmp_rel_encode
// Description : Combinational decode of comparator eq/lt/gt flags into a
//               relation code plus an illegal-combination flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_rel_encode
    import cmp_pkg::*;
(
    input  logic       i_eq,
    input  logic       i_lt,
    input  logic       i_gt,
    output logic [1:0] o_rel,
    output logic       o_illegal
);

    always_comb begin
        o_rel     = REL_UNK;
        o_illegal = 1'b0;
        case ({i_eq, i_lt, i_gt})
            3'b100:  o_rel = REL_EQ;
            3'b010:  o_rel = REL_LT;
            3'b001:  o_rel = REL_GT;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule : cmp_rel_encode
`default_nettype wire

// File: rtl/cmp_debounce.sv
`default_nettype none
// ============================================================================
// Module      : cmp_debounce
// Description : Debounces comparator relation flags; rel_o changes only after
//               STABLE_CNT consecutive agreeing valid samples. Optional change
//               counter enabled by macro CMP_DEB_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_debounce
    import cmp_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             lt,
    input  logic             gt,
    input  logic             clr_cnt,
    output logic [1:0]       rel_o,
    output logic             changed_o,
    output logic             err_o,
    output logic [CNT_W-1:0] chg_cnt_o
);

    localparam logic [c_RUN_W-1:0] c_STABLE = c_RUN_W'(STABLE_CNT);

    state_t             r_state, w_state_nxt;
    rel_t               r_rel, w_rel_nxt;
    rel_t               r_cand, w_cand_nxt;
    logic [c_RUN_W-1:0] r_run, w_run_nxt, w_run_tgt;
    logic               r_chg, w_chg_nxt;
    logic               r_err, w_err_nxt;

    logic [1:0]         w_s_raw;
    rel_t               w_s;
    logic               w_illegal;

    cmp_rel_encode u_enc (
        .i_eq      (eq),
        .i_lt      (lt),
        .i_gt      (gt),
        .o_rel     (w_s_raw),
        .o_illegal (w_illegal)
    );

    assign w_s = rel_t'(w_s_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_UNK;
            r_rel   <= REL_UNK;
            r_cand  <= REL_UNK;
            r_run   <= '0;
            r_chg   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rel   <= w_rel_nxt;
            r_cand  <= w_cand_nxt;
            r_run   <= w_run_nxt;
            r_chg   <= w_chg_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rel_nxt   = r_rel;
        w_cand_nxt  = r_cand;
        w_run_nxt   = r_run;
        w_chg_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_run_tgt   = 8'd1;
        if (in_valid) begin
            if (w_illegal) begin
                w_err_nxt   = 1'b1;
                w_run_nxt   = '0;
                w_cand_nxt  = REL_UNK;
                w_state_nxt = (r_rel == REL_UNK) ? S_UNK : S_LOCK;
            end else if (w_s == r_rel) begin
                w_run_nxt   = '0;
                w_cand_nxt  = REL_UNK;
                w_state_nxt = S_LOCK;
            end else begin
                // A run only continues while pending toward the same candidate
                if (r_state == S_PEND && w_s == r_cand)
                    w_run_tgt = r_run + 8'd1;
                if (w_run_tgt == c_STABLE) begin
                    w_rel_nxt   = w_s;
                    w_chg_nxt   = 1'b1;
                    w_run_nxt   = '0;
                    w_cand_nxt  = REL_UNK;
                    w_state_nxt = S_LOCK;
                end else begin
                    w_run_nxt   = w_run_tgt;
                    w_cand_nxt  = w_s;
                    w_state_nxt = S_PEND;
                end
            end
        end
    end

    assign rel_o     = r_rel;
    assign changed_o = r_chg;
    assign err_o     = r_err;

`ifdef CMP_DEB_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (clr_cnt)
            r_cnt <= '0;
        else if (w_chg_nxt && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
    end

    assign chg_cnt_o = r_cnt;
`else
    logic w_unused;
    assign w_unused  = clr_cnt;
    assign chg_cnt_o = '0;
`endif

endmodule : cmp_debounce
`default_nettype wire

// File: tb/tb_cmp_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_debounce
// Description : Self-checking bench for cmp_debounce: directed vector table
//               followed by randomized stimulus against a streak-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_debounce;

    localparam int STABLE_CNT = 4;
    localparam int CNT_W      = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, in_valid, eq, lt, gt, clr_cnt;
    logic [1:0]       rel_o;
    logic             changed_o, err_o;
    logic [CNT_W-1:0] chg_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cmp_debounce #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .eq        (eq),
        .lt        (lt),
        .gt        (gt),
        .clr_cnt   (clr_cnt),
        .rel_o     (rel_o),
        .changed_o (changed_o),
        .err_o     (err_o),
        .chg_cnt_o (chg_cnt_o)
    );

    typedef struct {
        string      nm;
        logic       r, v, c;
        logic [2:0] f;
        int         rel, chg, err, cnt;
    } vec_t;

    vec_t tbl[$];

    localparam logic [2:0] EQF = 3'b100;
    localparam logic [2:0] LTF = 3'b010;
    localparam logic [2:0] GTF = 3'b001;

    task automatic p(string nm, logic r, logic v, logic [2:0] f, logic c,
                     int rel, int chg, int err, int cnt);
        vec_t x;
        x.nm = nm; x.r = r; x.v = v; x.f = f; x.c = c;
        x.rel = rel; x.chg = chg; x.err = err; x.cnt = cnt;
        tbl.push_back(x);
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(int c);
`ifdef CMP_DEB_CNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic apply(logic r, logic v, logic [2:0] f, logic c);
        rst = r; in_valid = v; {eq, lt, gt} = f; clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(string nm, int rel, int chg, int err, int cnt);
        chk({nm, ".rel"}, int'(rel_o), rel);
        chk({nm, ".chg"}, int'(changed_o), chg);
        chk({nm, ".err"}, int'(err_o), err);
        chk({nm, ".cnt"}, int'(chg_cnt_o), exp_cnt(cnt));
    endtask

    // Reference: relation switches once the current streak of identical legal
    // samples, differing from the reported relation, reaches STABLE_CNT.
    int m_rel, m_last, m_streak, m_chg, m_err, m_cnt;

    task automatic model_step(logic r, logic v, logic [2:0] f, logic c);
        int s;
        m_chg = 0;
        m_err = 0;
        if (r) begin
            m_rel = 3; m_last = 3; m_streak = 0; m_cnt = 0;
            return;
        end
        if (v) begin
            if ($countones(f) != 1) begin
                m_err = 1; m_last = 3; m_streak = 0;
            end else begin
                s = (f == EQF) ? 0 : (f == LTF) ? 1 : 2;
                if (s == m_last) m_streak++;
                else begin m_last = s; m_streak = 1; end
                if (s != m_rel && m_streak >= STABLE_CNT) begin
                    m_rel = s; m_chg = 1; m_last = 3; m_streak = 0;
                end
            end
        end
        if (c) m_cnt = 0;
        else if (m_chg == 1 && m_cnt < CNT_MAX) m_cnt++;
    endtask

    initial begin
        logic [2:0] f;
        logic       r, v, c;
        int         prev;

        p("reset",  1, 0, 3'b000, 0, 3, 0, 0, 0);
        p("eq1",    0, 1, EQF,    0, 3, 0, 0, 0);
        p("eq2",    0, 1, EQF,    0, 3, 0, 0, 0);
        p("eq3",    0, 1, EQF,    0, 3, 0, 0, 0);
        p("eq4",    0, 1, EQF,    0, 0, 1, 0, 1);
        p("idle",   0, 0, 3'b000, 0, 0, 0, 0, 1);
        p("lt_a1",  0, 1, LTF,    0, 0, 0, 0, 1);
        p("lt_a2",  0, 1, LTF,    0, 0, 0, 0, 1);
        p("gt_brk", 0, 1, GTF,    0, 0, 0, 0, 1);
        p("lt_b1",  0, 1, LTF,    0, 0, 0, 0, 1);
        p("lt_b2",  0, 1, LTF,    0, 0, 0, 0, 1);
        p("lt_b3",  0, 1, LTF,    0, 0, 0, 0, 1);
        p("lt_b4",  0, 1, LTF,    0, 1, 1, 0, 2);
        p("gt1",    0, 1, GTF,    0, 1, 0, 0, 2);
        p("gt2",    0, 1, GTF,    0, 1, 0, 0, 2);
        for (int i = 0; i < 5; i++)
            p("gap",  0, 0, GTF,    0, 1, 0, 0, 2);
        p("gt3",    0, 1, GTF,    0, 1, 0, 0, 2);
        p("gt4",    0, 1, GTF,    0, 2, 1, 0, 3);
        p("lt_p1",  0, 1, LTF,    0, 2, 0, 0, 3);
        p("lt_p2",  0, 1, LTF,    0, 2, 0, 0, 3);
        p("ill110", 0, 1, 3'b110, 0, 2, 0, 1, 3);
        p("ill000", 0, 1, 3'b000, 0, 2, 0, 1, 3);
        p("inv111", 0, 0, 3'b111, 0, 2, 0, 0, 3);
        p("lt_r1",  0, 1, LTF,    0, 2, 0, 0, 3);
        p("lt_r2",  0, 1, LTF,    0, 2, 0, 0, 3);
        p("lt_r3",  0, 1, LTF,    0, 2, 0, 0, 3);
        p("lt_r4",  0, 1, LTF,    0, 1, 1, 0, 3);
        p("gt_q1",  0, 1, GTF,    0, 1, 0, 0, 3);
        p("gt_q2",  0, 1, GTF,    0, 1, 0, 0, 3);
        p("gt_q3",  0, 1, GTF,    0, 1, 0, 0, 3);
        p("rst_mid",1, 1, GTF,    0, 3, 0, 0, 0);
        p("gt_s1",  0, 1, GTF,    0, 3, 0, 0, 0);
        p("gt_s2",  0, 1, GTF,    0, 3, 0, 0, 0);
        p("gt_s3",  0, 1, GTF,    0, 3, 0, 0, 0);
        p("gt_s4",  0, 1, GTF,    0, 2, 1, 0, 1);
        p("eq_c1",  0, 1, EQF,    0, 2, 0, 0, 1);
        p("eq_c2",  0, 1, EQF,    0, 2, 0, 0, 1);
        p("eq_c3",  0, 1, EQF,    0, 2, 0, 0, 1);
        p("eq_clr", 0, 1, EQF,    1, 0, 1, 0, 0);
        p("lt_m1",  0, 1, LTF,    0, 0, 0, 0, 0);
        p("lt_m2",  0, 1, LTF,    0, 0, 0, 0, 0);
        p("eq_same",0, 1, EQF,    0, 0, 0, 0, 0);
        p("lt_m3",  0, 1, LTF,    0, 0, 0, 0, 0);
        p("lt_m4",  0, 1, LTF,    0, 0, 0, 0, 0);
        p("lt_m5",  0, 1, LTF,    0, 0, 0, 0, 0);
        p("lt_m6",  0, 1, LTF,    0, 1, 1, 0, 1);

        rst = 1'b1; in_valid = 1'b0; {eq, lt, gt} = 3'b000; clr_cnt = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].f, tbl[i].c);
            check_all(tbl[i].nm, tbl[i].rel, tbl[i].chg, tbl[i].err, tbl[i].cnt);
        end

        prev = 0;
        for (int n = 0; n < 3000; n++) begin
            r = (n == 0) || ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 11) == 0) begin
                f = 3'($urandom_range(0, 7));
            end else begin
                if ($urandom_range(0, 9) < 3) prev = $urandom_range(0, 2);
                f = (prev == 0) ? EQF : (prev == 1) ? LTF : GTF;
            end
            model_step(r, v, f, c);
            apply(r, v, f, c);
            check_all("rand", m_rel, m_chg, m_err, m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cmp_debounce
`default_nettype wire
